mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 4: maximum consecutive grants to port 0 while port 1 waits (fixed-priority mode only), legal range 1..15.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports p0_req / p1_req  input  1  requester wants one memory access this cycle.
REQ-005 SHALL have ports p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports p0_addr / p1_addr  input  16  byte address.
REQ-007 SHALL have ports p0_wdata / p1_wdata  input  8  write data.
REQ-008 SHALL have ports p0_gnt / p1_gnt  output  1  access accepted this cycle.
REQ-009 SHALL have ports p0_rvalid / p1_rvalid  output  1  read data valid this cycle.
REQ-010 SHALL have ports p0_rdata / p1_rdata  output  8  read data, both equal to mem_rdata at all times.
REQ-011 SHALL have ports mem_addr  output  16, mem_we  output  1, mem_wdata  output  8  to the synchronous 64 KB RAM.
REQ-012 SHALL have port mem_rdata  input  8  RAM read data, valid the cycle after a read is presented.

Function
REQ-013 SHALL make the grant decision combinationally from pX_req and registered arbiter state; at most one pX_gnt high per cycle.
REQ-014 SHALL, in a granted cycle, drive mem_addr/mem_we/mem_wdata from the winner; with no grant, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-015 SHALL consume a request in its grant cycle (single-beat); a requester holding pX_req high gets a new access each granted cycle, no idle gap.
REQ-016 SHALL require requesters to hold req, we, addr, wdata stable until gnt; an ungranted request SHALL NOT reach memory.
REQ-017 SHALL assert pX_rvalid exactly one cycle after a granted read by port X (1-cycle latency); never for writes.
REQ-018 SHALL keep a two-state FSM OWN0/OWN1 recording the last granted port; a no-grant cycle leaves state unchanged.
REQ-019 SHALL keep a 4-bit consecutive-grant counter: increment on port-0 grant while p1_req high, clear on any port-1 grant or when p1_req is low.
REQ-020 SHALL, when only one port requests, grant that port regardless of mode or counter.
REQ-021 SHALL, when both request (fixed-priority mode), grant port 0 unless counter == HOLD_MAX, then grant port 1 for exactly one cycle.
REQ-022 SHALL let a write and a read of the same address in consecutive cycles return the written value (memory write-first ordering preserved by grant order).

Reset
REQ-023 SHALL on rst_n low asynchronously force: state OWN1 (so port 0 is first in round-robin), counter 0, p0_rvalid=p1_rvalid=0.
REQ-024 SHALL hold p0_gnt=p1_gnt=0 and mem_we=0 while rst_n is low, regardless of requests.
REQ-025 SHALL discard a read granted in the cycle reset asserts: no rvalid after reset release.
REQ-026 SHALL accept requests in the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL support macro MEM_ARB_RR_EN; when undefined, arbitration is fixed-priority per REQ-021.
REQ-028 SHALL, with MEM_ARB_RR_EN defined, on simultaneous requests grant the port not recorded in the FSM (strict alternation); HOLD_MAX and counter unused (counter held 0).

Verification
REQ-029 SHALL test single read: memory preloaded 0x1234=0xA9; p0 read 0x1234 -> p0_gnt cycle T, p0_rvalid at T+1 with p0_rdata=0xA9, p1_rvalid stays 0.
REQ-030 SHALL test write then read: p1 write 0x0200=0x5C then read 0x0200 back-to-back -> two consecutive grants, p1_rvalid with 0x5C on third cycle.
REQ-031 SHALL test fixed priority, HOLD_MAX=4, both requesting continuously for 10 cycles -> grant pattern 0,0,0,0,1,0,0,0,0,1.
REQ-032 SHALL test MEM_ARB_RR_EN, both requesting continuously from reset for 6 cycles -> grant pattern 0,1,0,1,0,1.
REQ-033 SHALL test reset mid-read: p0 read granted, rst_n low before next edge -> p0_rvalid never asserts; first post-reset p1-only request granted immediately.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester port of mem_arbiter.
// Carries a single-beat access request (req/we/addr/wdata) plus the
// arbiter's accept strobe (gnt) and the read-return path (rvalid/rdata).
// The requester side uses the master modport; the arbiter uses slave.
interface mem_arbiter_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        gnt;
    logic        rvalid;
    logic [7:0]  rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a synchronous 64 KB RAM.
// Each grant is a single-beat access; reads return one cycle later.
// Default build: fixed priority to port 0, with port 1 forced in for one
// cycle after HOLD_MAX consecutive port-0 grants while port 1 waits.
// Optional macro MEM_ARB_RR_EN: strict alternation on simultaneous
// requests; the hold counter is then parked at zero.
module mem_arbiter #(
    parameter int unsigned HOLD_MAX = 4  // legal range 1..15
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  p0,
    mem_arbiter_if.slave  p1,
    output logic [15:0]   mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    // Owner state: last port that won the memory.
    localparam logic [0:0] OWN0 = 1'b0;
    localparam logic [0:0] OWN1 = 1'b1;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;
    logic       gnt0, gnt1;

    // Grant decision from live requests and registered arbiter state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // Reset level gates the grants so nothing reaches memory while held in reset.
        if (rst_n) begin
            if (p0.req && p1.req) begin
`ifdef MEM_ARB_RR_EN
                gnt1 = (state_q == OWN0);
`else
                gnt1 = (cnt_q == HOLD_LIM);
`endif
                gnt0 = !gnt1;
            end else begin
                gnt0 = p0.req;
                gnt1 = p1.req;
            end
        end
    end

    // Memory command mux: winner drives the bus, idle bus is all zero.
    always_comb begin
        mem_addr  = 16'h0000;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (gnt0) begin
            mem_addr  = p0.addr;
            mem_we    = p0.we;
            mem_wdata = p0.wdata;
        end else if (gnt1) begin
            mem_addr  = p1.addr;
            mem_we    = p1.we;
            mem_wdata = p1.wdata;
        end
    end

    // Next-state: owner, hold counter and read-return strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rvalid0_d = gnt0 && !p0.we;
        rvalid1_d = gnt1 && !p1.we;

        if (gnt0) begin
            state_d = OWN0;
        end else if (gnt1) begin
            state_d = OWN1;
        end

`ifdef MEM_ARB_RR_EN
        cnt_d = 4'd0;
`else
        // Counts port-0 wins only while port 1 is actually waiting.
        if (gnt1 || !p1.req) begin
            cnt_d = 4'd0;
        end else if (gnt0) begin
            cnt_d = cnt_q + 4'd1;
        end
`endif
    end

    // State registers; reset makes port 0 first in alternation and drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OWN1;
            cnt_q     <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign p0.gnt    = gnt0;
    assign p1.gnt    = gnt1;
    assign p0.rvalid = rvalid0_q;
    assign p1.rvalid = rvalid1_q;
    assign p0.rdata  = mem_rdata;
    assign p1.rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked against a behavioural model of the arbitration rules and a byte
// array standing in for memory contents. Honors MEM_ARB_RR_EN like the DUT.
module tb_mem_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    mem_arbiter_if p0 ();
    mem_arbiter_if p1 ();

    mem_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p0.slave),
        .p1        (p1.slave),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM environment: read returns the pre-edge contents.
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    // Reference state
    logic [7:0] ref_mem [0:65535];
    int  m_last;          // port that last won (1 after reset)
    int  m_wins;          // port-0 wins in a row while port 1 waits
    bit  exp_rv0, exp_rv1;
    logic [7:0] exp_rd0, exp_rd1;
    bit  eg0, eg1;        // expected grants of the current cycle
    int  obs_win;         // observed winner: 0, 1 or -1
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = 1;
        m_wins  = 0;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
    endtask

    // Arbitration rules expressed directly on request bits and win history.
    task automatic model_grant(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_n) begin
            if (p0.req && !p1.req) g0 = 1'b1;
            else if (p1.req && !p0.req) g1 = 1'b1;
            else if (p0.req && p1.req) begin
`ifdef MEM_ARB_RR_EN
                if (m_last == 0) g1 = 1'b1; else g0 = 1'b1;
`else
                if (m_wins == HOLD) g1 = 1'b1; else g0 = 1'b1;
`endif
            end
        end
    endtask

    // Mid-cycle sample: grants, memory bus and read return.
    task automatic sample();
        @(negedge clk);
        model_grant(eg0, eg1);
        obs_win = p0.gnt ? 0 : (p1.gnt ? 1 : -1);
        check("p0_gnt", p0.gnt, eg0);
        check("p1_gnt", p1.gnt, eg1);
        check("mem_we", mem_we, eg0 ? p0.we : (eg1 ? p1.we : 1'b0));
        check("mem_addr", mem_addr, eg0 ? p0.addr : (eg1 ? p1.addr : 16'h0));
        check("mem_wdata", mem_wdata, eg0 ? p0.wdata : (eg1 ? p1.wdata : 8'h0));
        check("p0_rvalid", p0.rvalid, exp_rv0);
        check("p1_rvalid", p1.rvalid, exp_rv1);
        if (exp_rv0) check("p0_rdata", p0.rdata, exp_rd0);
        if (exp_rv1) check("p1_rdata", p1.rdata, exp_rd1);
    endtask

    // Clock edge: advance the model with the grants sampled this cycle.
    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_rv0 = eg0 && !p0.we;
            exp_rv1 = eg1 && !p1.we;
            if (exp_rv0) exp_rd0 = ref_mem[p0.addr];
            if (exp_rv1) exp_rd1 = ref_mem[p1.addr];
            if (eg0 && p0.we) ref_mem[p0.addr] = p0.wdata;
            if (eg1 && p1.we) ref_mem[p1.addr] = p1.wdata;
            if (eg0) m_last = 0;
            if (eg1) m_last = 1;
            if (eg1 || !p1.req) m_wins = 0;
            else if (eg0) m_wins++;
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic drive(input int port, input bit req, input bit we,
                         input logic [15:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            p0.req = req; p0.we = we; p0.addr = addr; p0.wdata = wdata;
        end else begin
            p1.req = req; p1.we = we; p1.addr = addr; p1.wdata = wdata;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int pat_fix [10];
        int pat_rr  [6];
        bit hold0, hold1;
        pat_fix = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        pat_rr  = '{0, 1, 0, 1, 0, 1};

        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 8'(i ^ (i >> 8));
            ref_mem[i] = 8'(i ^ (i >> 8));
        end
        ram[16'h1234]     = 8'hA9;
        ref_mem[16'h1234] = 8'hA9;

        // Reset with both ports requesting writes: nothing may be granted.
        drive(0, 1'b1, 1'b1, 16'h0010, 8'h11);
        drive(1, 1'b1, 1'b1, 16'h0020, 8'h22);
        #2;
        apply_reset();

        // Single read by port 0.
        drive(0, 1'b1, 1'b0, 16'h1234, 8'h00);
        drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        cycle();
        check("single_gnt", p0.gnt, 1'b1);
        drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        sample();
        check("single_rvalid", p0.rvalid, 1'b1);
        check("single_rdata", p0.rdata, 8'hA9);
        check("single_p1_rvalid", p1.rvalid, 1'b0);
        advance();

        // Port 1 write then read of the same address back-to-back.
        drive(1, 1'b1, 1'b1, 16'h0200, 8'h5C);
        cycle();
        check("wr_gnt", p1.gnt, 1'b1);
        drive(1, 1'b1, 1'b0, 16'h0200, 8'h00);
        cycle();
        check("rd_gnt", p1.gnt, 1'b1);
        drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        sample();
        check("wr_rd_rvalid", p1.rvalid, 1'b1);
        check("wr_rd_rdata", p1.rdata, 8'h5C);
        advance();

        // Both ports requesting continuously from reset.
        drive(0, 1'b1, 1'b0, 16'h0400, 8'h00);
        drive(1, 1'b1, 1'b0, 16'h0401, 8'h00);
        apply_reset();
`ifdef MEM_ARB_RR_EN
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_pattern", obs_win, pat_rr[i]);
        end
`else
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("fixed_pattern", obs_win, pat_fix[i]);
        end
`endif

        // Randomized traffic; an ungranted request holds its fields stable.
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            hold0 = p0.req && !eg0;
            hold1 = p1.req && !eg1;
            if (!hold0)
                drive(0, $urandom_range(0, 9) < 6, 1'($urandom), 16'h0300 + 16'($urandom_range(0, 7)), 8'($urandom));
            if (!hold1)
                drive(1, $urandom_range(0, 9) < 7, 1'($urandom), 16'h0300 + 16'($urandom_range(0, 7)), 8'($urandom));
            cycle();
        end

        // Reset asserted right after a granted read: the read is dropped.
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(0, 1'b1, 1'b0, 16'h1234, 8'h0);
        cycle();
        sample();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_rvalid_drop", p0.rvalid, 1'b0);
        check("rst_gnt_gated", p0.gnt, 1'b0);
        advance();
        cycle();
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b1, 1'b0, 16'h0055, 8'h0);
        sample();
        check("post_rst_p1_gnt", p1.gnt, 1'b1);
        check("post_rst_p0_rvalid", p0.rvalid, 1'b0);
        advance();
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
